// File: rtl/buck_pkg.sv
// buck_pkg: shared constants and FSM encoding for the buck power-stage control blocks
package buck_pkg;
    localparam int DT_WIDTH_DEFAULT = 8;
    localparam int CLK_FREQ_HZ = 100_000_000;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DT_HS = 3'd1,
        HS_ON = 3'd2,
        DT_LS = 3'd3,
        LS_ON = 3'd4
    } state_t;
endpackage

// File: rtl/dead_counter.sv
// dead_counter: loadable down-counter that holds at zero and flags it
module dead_counter
    import buck_pkg::*;
#(
    parameter int WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);
    logic [WIDTH-1:0] count;
    // load on DT entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - 1'b1;
    assign zero = (count == '0);
endmodule

// File: rtl/dead_time_generator.sv
// dead_time_generator: complementary gate drive with dead time, pulse absorption and fault latch
module dead_time_generator
    import buck_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                gate_hs,
    output logic                gate_ls,
    output logic                fault_latched
);
    state_t state, state_nx;
    logic cnt_zero, cnt_load;
    // next state: fault, disable or a latched fault park the FSM in IDLE
    always_comb begin
        state_nx = IDLE;
        if (enable && !fault && !fault_latched)
            case (state)
                IDLE:    state_nx = pwm_in ? DT_HS : DT_LS;
                DT_HS:   state_nx = !pwm_in ? DT_LS : (cnt_zero ? HS_ON : DT_HS);
                HS_ON:   state_nx = pwm_in ? HS_ON : DT_LS;
                DT_LS:   state_nx = pwm_in ? DT_HS : (cnt_zero ? LS_ON : DT_LS);
                LS_ON:   state_nx = pwm_in ? DT_HS : LS_ON;
                default: state_nx = IDLE;
            endcase
    end
    assign cnt_load = (state_nx == DT_HS && state != DT_HS) || (state_nx == DT_LS && state != DT_LS);
    dead_counter #(.WIDTH(DT_WIDTH)) u_dead_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .value (dead_time),
        .zero  (cnt_zero)
    );
    // state, fault latch and gate drives decoded from the next state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            gate_hs       <= 1'b0;
            gate_ls       <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_nx;
            gate_hs       <= (state_nx == HS_ON);
            gate_ls       <= (state_nx == LS_ON);
            fault_latched <= fault ? 1'b1 : (fault_clr ? 1'b0 : fault_latched);
        end
endmodule

// File: tb/tb_dead_time_generator.sv
// tb_dead_time_generator: run-length reference model plus directed dead-time scenarios
module tb_dead_time_generator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic pwm_in = 1'b0;
    logic [7:0] dead_time = 8'd0;
    logic fault = 1'b0;
    logic fault_clr = 1'b0;
    logic gate_hs, gate_ls, fault_latched;
    int n_cmp = 0;
    int n_bad = 0;
    int m_run = 0, m_lvl = 0, m_stable = 0, m_dt = 0, m_fl = 0, m_old = 0;
    logic e_hs, e_ls;

    dead_time_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .gate_hs       (gate_hs),
        .gate_ls       (gate_ls),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    // reference: a gate conducts once its pwm level has been seen on more than dt+1 consecutive running edges
    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_lvl = 0; m_stable = 0; m_dt = 0; m_fl = 0;
        end else begin
            m_old = m_fl;
            if (fault) m_fl = 1;
            else if (fault_clr) m_fl = 0;
            if (!enable || fault || m_old != 0) m_run = 0;
            else if (m_run == 0 || int'(pwm_in) != m_lvl) begin
                m_run = 1; m_lvl = int'(pwm_in); m_stable = 1; m_dt = int'(dead_time);
            end else if (m_stable < 1000) m_stable++;
        end
        #1;
        e_hs = (m_run != 0) && (m_lvl == 1) && (m_stable >= m_dt + 2);
        e_ls = (m_run != 0) && (m_lvl == 0) && (m_stable >= m_dt + 2);
        n_cmp++;
        if ({gate_hs, gate_ls, fault_latched} !== {e_hs, e_ls, m_fl[0]}) begin
            n_bad++;
            $display("FAIL model t=%0t: hs/ls/flt got %b%b%b want %b%b%b", $time,
                     gate_hs, gate_ls, fault_latched, e_hs, e_ls, m_fl[0]);
        end
        n_cmp++;
        if (gate_hs === 1'b1 && gate_ls === 1'b1) begin
            n_bad++;
            $display("FAIL overlap t=%0t: both gates got 1 want not both", $time);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // steps until the requested gate is on; n = steps taken, -1 if the bound expires
    task automatic gap(input bit to_hs, input int lim, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(to_hs ? gate_hs : gate_ls) && n < lim);
        if (!(to_hs ? gate_hs : gate_ls)) n = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation got stuck, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, hs_c, ls_c, off_c, seen;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pwm_in = ~pwm_in;
            step(1);
        end
        chk("reset_hs", gate_hs, 0);
        chk("reset_ls", gate_ls, 0);
        chk("reset_flt", fault_latched, 0);
        pwm_in = 1'b0; dead_time = 8'd4; rst_n = 1'b1;
        step(5);
        chk("start_ls_early", gate_ls, 0);
        step(1);
        chk("start_ls_rise", gate_ls, 1);

        dead_time = 8'd10;
        for (int p = 0; p < 2; p++) begin
            hs_c = 0; ls_c = 0; off_c = 0;
            pwm_in = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                if (i == 500) pwm_in = 1'b0;
                step(1);
                if (gate_hs) hs_c++;
                if (gate_ls) ls_c++;
                if (!gate_hs && !gate_ls) off_c++;
            end
            chk("period_hs", hs_c, 489);
            chk("period_ls", ls_c, 489);
            chk("period_off", off_c, 22);
        end

        pwm_in = 1'b1; seen = 0;
        step(1);
        chk("pulse_ls_off", gate_ls, 0);
        seen |= int'(gate_hs);
        for (int i = 0; i < 5; i++) begin
            step(1);
            seen |= int'(gate_hs);
        end
        pwm_in = 1'b0;
        gap(1'b0, 40, n);
        chk("pulse_hs_never", seen, 0);
        chk("pulse_ls_return", n, 12);

        dead_time = 8'd0; pwm_in = 1'b1;
        gap(1'b1, 20, n);
        chk("dt0_rise", n, 2);
        pwm_in = 1'b0;
        gap(1'b0, 20, n);
        chk("dt0_fall", n, 2);

        dead_time = 8'd255; pwm_in = 1'b1;
        gap(1'b1, 300, n);
        chk("dtmax_rise", n, 257);
        pwm_in = 1'b0;
        step(100);
        dead_time = 8'd3;
        gap(1'b0, 300, n);
        chk("dtmax_midchange", n, 157);
        pwm_in = 1'b1;
        gap(1'b1, 20, n);
        chk("dt3_after_change", n, 5);

        fault = 1'b1;
        step(1);
        chk("fault_hs", gate_hs, 0);
        chk("fault_latch", fault_latched, 1);
        fault_clr = 1'b1;
        step(1);
        chk("clr_blocked", fault_latched, 1);
        fault = 1'b0; fault_clr = 1'b0;
        step(3);
        chk("fault_sticky", fault_latched, 1);
        chk("fault_idle_hs", gate_hs, 0);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("fault_cleared", fault_latched, 0);
        gap(1'b1, 20, n);
        chk("fault_resume", n, 5);

        pwm_in = 1'b0;
        gap(1'b0, 20, n);
        chk("en_pre_ls", n, 5);
        pwm_in = 1'b1;
        step(2);
        chk("en_dths_ls", gate_ls, 0);
        enable = 1'b0;
        step(1);
        chk("en_drop_hs", gate_hs, 0);
        chk("en_drop_ls", gate_ls, 0);
        step(3);
        enable = 1'b1;
        gap(1'b1, 20, n);
        chk("en_resume", n, 5);
        enable = 1'b0;
        step(1);
        chk("en_drop_hson", gate_hs, 0);

        enable = 1'b1;
        gap(1'b1, 20, n);
        chk("pre_reset_hs", n, 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_hs", gate_hs, 0);
        step(2);
        rst_n = 1'b1;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
